// File: rtl/free_slot_tracker.sv
// free_slot_tracker: writer side of the free/busy bitmap scanned by find_first1_base.
// Allocations clear bits, releases set them, and a flush marks everything free.
// The block also keeps a rotating search base and a registered free-slot count.
// Optional build macro: FREE_SLOT_TRACKER_ERR_EN adds the sticky misuse flags err_sticky[2:0].
module free_slot_tracker #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             alloc_valid,
    input  logic [IDX_W-1:0] alloc_idx,
    output logic             alloc_ready,
    input  logic             release_valid,
    input  logic [IDX_W-1:0] release_idx,
    output logic [WIDTH-1:0] free_mask,
    output logic [WIDTH-1:0] search_base,
    output logic [IDX_W:0]   free_count,
`ifdef FREE_SLOT_TRACKER_ERR_EN
    output logic [2:0]       err_sticky,
`endif
    output logic             any_free
);

    logic             alloc_fire;
    logic             release_fire;
    logic             alloc_in_range;
    logic [WIDTH-1:0] alloc_onehot;
    logic [WIDTH-1:0] release_onehot;
    logic [WIDTH-1:0] next_mask;
    logic [WIDTH-1:0] next_base;
    logic [IDX_W:0]   candidate;

    // Number of 1 bits in a mask.
    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] mask);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + (IDX_W+1)'(mask[i]);
        end
        return cnt;
    endfunction

    // True when mask holds a 1 at any position >= pos.
    function automatic logic has_one_from(input logic [WIDTH-1:0] mask, input int pos);
        logic found;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mask[i] && (i >= pos)) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

    assign any_free       = (free_count != '0);
    assign alloc_ready    = any_free & ~flush;
    assign alloc_fire     = alloc_valid & alloc_ready;
    assign alloc_in_range = (int'(alloc_idx) < WIDTH);
    assign release_fire   = release_valid & (int'(release_idx) < WIDTH);

    // Next bitmap and search base: alloc clears first, release sets last so it wins on a tie.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
        alloc_onehot   = '0;
        release_onehot = '0;
        next_base      = search_base;
        candidate      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (alloc_fire && (int'(alloc_idx) == i)) begin
                alloc_onehot[i] = 1'b1;
            end
            if (release_fire && (int'(release_idx) == i)) begin
                release_onehot[i] = 1'b1;
            end
        end
        next_mask = (free_mask & ~alloc_onehot) | release_onehot;

        if (alloc_fire) begin
            candidate = (int'(alloc_idx) == WIDTH - 1) ? '0 : ((IDX_W+1)'(alloc_idx) + 1'b1);
            next_base = has_one_from(next_mask, int'(candidate)) ? WIDTH'(candidate) : '0;
        end else if (!has_one_from(next_mask, int'(search_base))) begin
            next_base = '0;
        end
    end

    // State registers: reset, then flush, then normal alloc/release update.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset || flush) begin
            free_mask   <= '1;
            search_base <= '0;
            free_count  <= (IDX_W+1)'(WIDTH);
        end else begin
            free_mask   <= next_mask;
            search_base <= next_base;
            free_count  <= popcount(next_mask);
        end
    end

`ifdef FREE_SLOT_TRACKER_ERR_EN
    logic [2:0] err_set;

    // Misuse detection; flush cycles ignore both ports, so they flag nothing.
    always_comb begin
        err_set = '0;
        if (!flush) begin
            if (alloc_fire && alloc_in_range && !free_mask[alloc_idx]) begin
                err_set[0] = 1'b1;
            end
            if (release_fire && free_mask[release_idx]
                && !(alloc_fire && (alloc_idx == release_idx))) begin
                err_set[1] = 1'b1;
            end
            if ((alloc_fire && !alloc_in_range)
                || (release_valid && (int'(release_idx) >= WIDTH))) begin
                err_set[2] = 1'b1;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_sticky <= '0;
        end else begin
            err_sticky <= err_sticky | err_set;
        end
    end
`endif

endmodule

// File: tb/tb_free_slot_tracker.sv
// Directed self-checking bench for free_slot_tracker (WIDTH=8).
// Define FREE_SLOT_TRACKER_ERR_EN to also exercise the sticky error flags.
module tb_free_slot_tracker;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             flush;
    logic             alloc_valid;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_ready;
    logic             release_valid;
    logic [IDX_W-1:0] release_idx;
    logic [WIDTH-1:0] free_mask;
    logic [WIDTH-1:0] search_base;
    logic [IDX_W:0]   free_count;
    logic             any_free;
`ifdef FREE_SLOT_TRACKER_ERR_EN
    logic [2:0]       err_sticky;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    free_slot_tracker #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_idx    (alloc_idx),
        .alloc_ready  (alloc_ready),
        .release_valid(release_valid),
        .release_idx  (release_idx),
        .free_mask    (free_mask),
        .search_base  (search_base),
        .free_count   (free_count),
`ifdef FREE_SLOT_TRACKER_ERR_EN
        .err_sticky   (err_sticky),
`endif
        .any_free     (any_free)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic av, input int ai, input logic rv, input int ri);
        alloc_valid   = av;
        alloc_idx     = IDX_W'(ai);
        release_valid = rv;
        release_idx   = IDX_W'(ri);
    endtask

    task automatic expect_state(input string tag, input logic [7:0] m, input int b, input int c);
        check({tag, "_mask"},  32'(free_mask),   32'(m));
        check({tag, "_base"},  32'(search_base), 32'(b));
        check({tag, "_count"}, 32'(free_count),  32'(c));
    endtask

    initial begin
        logic [7:0] m;
        reset = 1'b1;
        flush = 1'b0;
        drive(0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        expect_state("reset", 8'hff, 0, 8);
        check("reset_any_free", 32'(any_free), 1);
        check("reset_ready", 32'(alloc_ready), 1);

        // Fill all slots in order.
        for (int i = 0; i < 8; i++) begin
            drive(1, i, 0, 0);
            tick();
            m = 8'hff;
            m = m << (i + 1);
            expect_state($sformatf("fill%0d", i), m, (i == 7) ? 0 : i + 1, 7 - i);
        end
        drive(0, 0, 0, 0);
        #1;
        check("full_ready", 32'(alloc_ready), 0);
        check("full_any_free", 32'(any_free), 0);

        // Full: release 5 with an alloc attempt that must not be accepted.
        drive(1, 3, 1, 5);
        #1;
        check("full_rel_same_cycle_ready", 32'(alloc_ready), 0);
        tick();
        expect_state("rel5", 8'h20, 0, 1);
        check("rel5_ready", 32'(alloc_ready), 1);
        drive(1, 5, 0, 0);
        tick();
        expect_state("alloc5", 8'h00, 0, 0);

        // Release 2 to reach mask=04, then alloc 2 with release 6.
        drive(0, 0, 1, 2);
        tick();
        expect_state("rel2", 8'h04, 0, 1);
        drive(1, 2, 1, 6);
        tick();
        expect_state("a2r6", 8'h40, 3, 1);

        // Reach mask=08, then alloc and release 3 together.
        drive(1, 6, 1, 3);
        tick();
        expect_state("a6r3", 8'h08, 0, 1);
        drive(1, 3, 1, 3);
        tick();
        expect_state("a3r3", 8'h08, 0, 1);
`ifdef FREE_SLOT_TRACKER_ERR_EN
        check("a3r3_err", 32'(err_sticky), 0);
`endif

        // Releasing a free slot and allocating a busy slot leave the mask alone.
        drive(0, 0, 1, 3);
        tick();
        expect_state("rel_free3", 8'h08, 0, 1);
        drive(1, 0, 0, 0);
        tick();
        expect_state("alloc_busy0", 8'h08, 1, 1);

        // Build mask=0f through single releases.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, i);
            tick();
        end
        expect_state("mask0f", 8'h0f, 1, 4);

        // Flush with an alloc in flight.
        drive(1, 4, 0, 0);
        flush = 1'b1;
        #1;
        check("flush_ready", 32'(alloc_ready), 0);
        tick();
        flush = 1'b0;
        expect_state("flush", 8'hff, 0, 8);

        // Reset with an alloc in flight.
        drive(1, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0);
        expect_state("reset_mid", 8'hff, 0, 8);

`ifdef FREE_SLOT_TRACKER_ERR_EN
        check("err_after_reset", 32'(err_sticky), 0);
        for (int i = 0; i < 8; i++) begin
            if (i != 1) begin
                drive(1, i, 0, 0);
                tick();
            end
        end
        drive(0, 0, 0, 0);
        check("err_mask02", 32'(free_mask), 32'h02);
        check("err_none_yet", 32'(err_sticky), 0);
        drive(0, 0, 1, 1);
        tick();
        check("err_rel_free", 32'(err_sticky), 32'b010);
        drive(1, 0, 0, 0);
        tick();
        check("err_alloc_busy", 32'(err_sticky), 32'b011);
        drive(0, 0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("err_hold", 32'(err_sticky), 32'b011);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("err_cleared", 32'(err_sticky), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
